sink_req_arbiter: RTL and testbench
===================================

Name: sink_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sink-side AHB master command port (valid/ready, rd0_wr1, addr, wr_data, rd_valid/rd_data) between NUM_REQ sink controllers.
- Latches the winning command, drives it to the master, returns read data to the originating requester, and handles a sleep request/acknowledge handshake.
- Sits between the sink controllers and ahb_master inside a multi-channel sink top.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
NUM_REQ, 2, number of requesters (2..8)
GNT_W, 1, grant index width, equal to clog2(NUM_REQ)

Ports:
i_clk_sink  in  1  sink clock; one clock only
i_rstn_sink  in  1  asynchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester command valid
i_req_rd0_wr1  in  NUM_REQ  per-requester direction; 0 = read, 1 = write
i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
i_req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data
o_req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
o_rsp_valid  out  NUM_REQ  one-cycle read-data-valid pulse to the originating requester
o_rsp_data  out  DATA_WIDTH  read data; shared by all requesters
o_valid  out  1  command valid to the master
o_rd0_wr1  out  1  command direction to the master
o_addr  out  ADDR_WIDTH  command address to the master
o_wr_data  out  DATA_WIDTH  command write data to the master
i_ready  in  1  master accepts the command when high while o_valid is high
i_rd_valid  in  1  master read data valid
i_rd_data  in  DATA_WIDTH  master read data
i_sleep_req  in  1  sleep request
o_sleep_ack  out  1  sleep acknowledge
o_grant_id  out  GNT_W  index of the current or last grant (debug)

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the round-robin pointer is 0. Reset is asynchronous at any time; any in-flight command or read is discarded and no pulse is emitted.
- All outputs are registered.
- State IDLE:
  - If i_sleep_req is high, go to SLEEP. Sleep wins over pending requests in the same cycle.
  - Otherwise, if any i_req_valid is high, grant g = the first set bit searched from the pointer upward, wrapping modulo NUM_REQ.
  - Next cycle: latch the command of g into o_rd0_wr1/o_addr/o_wr_data, set o_valid=1, pulse o_req_ready[g] for exactly one cycle, set o_grant_id=g, set pointer=(g+1) mod NUM_REQ, and go to ISSUE.
- Requester rule: a requester holds its fields stable while valid and not yet acknowledged. It may drop valid only after o_req_ready. Fields are sampled only in the grant cycle.
- State ISSUE:
  - o_valid and the command fields are held until i_ready=1.
  - On i_ready=1 for a write: o_valid=0 next cycle, go to IDLE.
  - On i_ready=1 for a read: o_valid=0 next cycle, go to WAIT_RD.
- State WAIT_RD:
  - On i_rd_valid=1: next cycle o_rsp_data=i_rd_data and o_rsp_valid[g]=1 for one cycle, go to IDLE.
  - o_rsp_data holds its value until the next read completes.
  - i_rd_valid in any other state is ignored.
- Latency and throughput:
  - Request to o_valid: 1 cycle.
  - At most one outstanding command.
  - Back-to-back writes with i_ready tied high take at least 2 cycles per write (one IDLE cycle between grants).
- Sleep:
  - i_sleep_req asserted during ISSUE or WAIT_RD does not abort the transaction. It completes, then IDLE sees i_sleep_req and enters SLEEP.
  - SLEEP: o_sleep_ack=1 (registered, the cycle after entry), no grants. On i_sleep_req=0, go to IDLE with o_sleep_ack=0 next cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.

Test Plan:
- Reset mid-read: assert i_rstn_sink=0 in WAIT_RD, then release. -> All outputs are 0, no o_rsp_valid pulse, and the next grant goes to requester 0.
- Single write: req0 write with addr 0x1000 and data 0xA5A5A5A5, i_ready=1. -> o_valid high exactly 1 cycle with those fields, o_req_ready[0] pulsed once, state returns to IDLE.
- Read with stall: req1 read of addr 0x20, i_ready low 3 cycles, then i_rd_valid with data 0xDEADBEEF. -> o_valid held 4 cycles, o_rsp_valid[1] single pulse with o_rsp_data=0xDEADBEEF, o_rsp_valid[0] stays 0.
- Fairness: req0 and req1 valid continuously with writes. -> grants alternate 0,1,0,1 and o_grant_id matches each o_req_ready pulse.
- Sleep during read: i_sleep_req rises in ISSUE for a read. -> the read completes and its response is delivered, then o_sleep_ack=1. No grant occurs while ack is high, even with req0 valid. Dropping i_sleep_req clears ack and req0 is granted.
- Simultaneous sleep and request in IDLE: both arrive in the same cycle. -> no o_req_ready pulse and o_sleep_ack asserts the next cycle.

Source files
------------

// File: rtl/sink_req_arbiter.sv
// Round-robin arbiter sharing one AHB master command port between NUM_REQ sink controllers.
// Grants one command at a time, returns read data to its originator, and handles sleep.
module sink_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int GNT_W      = 1
) (
  input  logic                          i_clk_sink,
  input  logic                          i_rstn_sink,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_valid,
  output logic                          o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  input  logic                          i_ready,
  input  logic                          i_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_rd_data,
  input  logic                          i_sleep_req,
  output logic                          o_sleep_ack,
  output logic [GNT_W-1:0]              o_grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, SLEEP} state_t;

  state_t                  state, state_nxt;
  logic [GNT_W-1:0]        ptr, ptr_nxt;
  logic                    any_req;
  logic [GNT_W-1:0]        win;

  logic [NUM_REQ-1:0]      req_ready_nxt, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   rsp_data_nxt, wr_data_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    valid_nxt, rd0_wr1_nxt, sleep_ack_nxt;
  logic [GNT_W-1:0]        grant_id_nxt;

  function automatic logic [GNT_W-1:0] wrap_idx(input int base, input int off);
    return GNT_W'((base + off) % NUM_REQ);
  endfunction

  // Search starts at the pointer so the last winner has lowest priority next time.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && i_req_valid[wrap_idx(int'(ptr), k)]) begin
        any_req = 1'b1;
        win     = wrap_idx(int'(ptr), k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_sleep_req) state_nxt = SLEEP;
               else if (any_req) state_nxt = ISSUE;
      ISSUE:   if (i_ready) state_nxt = o_rd0_wr1 ? IDLE : WAIT_RD;
      WAIT_RD: if (i_rd_valid) state_nxt = IDLE;
      SLEEP:   if (!i_sleep_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    valid_nxt     = o_valid;
    rd0_wr1_nxt   = o_rd0_wr1;
    addr_nxt      = o_addr;
    wr_data_nxt   = o_wr_data;
    grant_id_nxt  = o_grant_id;
    rsp_data_nxt  = o_rsp_data;
    ptr_nxt       = ptr;
    req_ready_nxt = '0;
    rsp_valid_nxt = '0;
    sleep_ack_nxt = (state_nxt == SLEEP);
    case (state)
      IDLE: begin
        if (!i_sleep_req && any_req) begin
          valid_nxt          = 1'b1;
          rd0_wr1_nxt        = i_req_rd0_wr1[win];
          addr_nxt           = i_req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          wr_data_nxt        = i_req_wr_data[win*DATA_WIDTH +: DATA_WIDTH];
          req_ready_nxt[win] = 1'b1;
          grant_id_nxt       = win;
          ptr_nxt            = wrap_idx(int'(win), 1);
        end
      end
      ISSUE: if (i_ready) valid_nxt = 1'b0;
      WAIT_RD: begin
        if (i_rd_valid) begin
          rsp_data_nxt              = i_rd_data;
          rsp_valid_nxt[o_grant_id] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      state       <= IDLE;
      ptr         <= '0;
      o_valid     <= 1'b0;
      o_rd0_wr1   <= 1'b0;
      o_addr      <= '0;
      o_wr_data   <= '0;
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_sleep_ack <= 1'b0;
      o_grant_id  <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      o_valid     <= valid_nxt;
      o_rd0_wr1   <= rd0_wr1_nxt;
      o_addr      <= addr_nxt;
      o_wr_data   <= wr_data_nxt;
      o_req_ready <= req_ready_nxt;
      o_rsp_valid <= rsp_valid_nxt;
      o_rsp_data  <= rsp_data_nxt;
      o_sleep_ack <= sleep_ack_nxt;
      o_grant_id  <= grant_id_nxt;
    end
  end

endmodule

// File: tb/tb_sink_req_arbiter.sv
// Self-checking bench for sink_req_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_sink_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int GW = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_rd0_wr1 = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wr_data = '0;
  logic [N-1:0]      o_req_ready, o_rsp_valid;
  logic [DW-1:0]     o_rsp_data, o_wr_data;
  logic              o_valid, o_rd0_wr1, o_sleep_ack;
  logic [AW-1:0]     o_addr;
  logic [GW-1:0]     o_grant_id;
  logic              i_ready = 1'b0;
  logic              i_rd_valid = 1'b0;
  logic [DW-1:0]     i_rd_data = '0;
  logic              i_sleep_req = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  sink_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .GNT_W(GW)) dut (
    .i_clk_sink(clk), .i_rstn_sink(rst_n),
    .i_req_valid(req_valid), .i_req_rd0_wr1(req_rd0_wr1),
    .i_req_addr(req_addr), .i_req_wr_data(req_wr_data),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_valid(o_valid), .o_rd0_wr1(o_rd0_wr1), .o_addr(o_addr), .o_wr_data(o_wr_data),
    .i_ready(i_ready), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .i_sleep_req(i_sleep_req), .o_sleep_ack(o_sleep_ack), .o_grant_id(o_grant_id)
  );

  always #5 clk = ~clk;

  // Transaction-level view: is a command outstanding, has the master taken it, are we asleep.
  typedef struct {
    bit            busy;
    bit            taken;
    bit            sleeping;
    int            ptr;
    logic          valid;
    logic          rd0_wr1;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          sleep_ack;
    int            grant_id;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.busy = 0; r.taken = 0; r.sleeping = 0; r.ptr = 0;
    r.valid = 0; r.rd0_wr1 = 0; r.addr = '0; r.wr_data = '0;
    r.req_ready = '0; r.rsp_valid = '0; r.rsp_data = '0;
    r.sleep_ack = 0; r.grant_id = 0;
    return r;
  endfunction

  // Winner = requester with the smallest rotational distance from the pointer.
  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int d = 0; d < N; d++)
      if (v[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  function automatic model_t step(input model_t c);
    model_t n;
    int g;
    n = c;
    n.req_ready = '0;
    n.rsp_valid = '0;
    if (c.sleeping) begin
      if (!i_sleep_req) n.sleeping = 0;
    end else if (!c.busy) begin
      if (i_sleep_req) n.sleeping = 1;
      else if (req_valid != '0) begin
        g = pick(c.ptr, req_valid);
        n.busy = 1; n.taken = 0; n.valid = 1;
        n.rd0_wr1      = req_rd0_wr1[g];
        n.addr         = req_addr[g*AW +: AW];
        n.wr_data      = req_wr_data[g*DW +: DW];
        n.req_ready[g] = 1'b1;
        n.grant_id     = g;
        n.ptr          = (g + 1) % N;
      end
    end else if (!c.taken) begin
      if (i_ready) begin
        n.valid = 0;
        if (c.rd0_wr1) n.busy = 0;
        else n.taken = 1;
      end
    end else if (i_rd_valid) begin
      n.rsp_data = i_rd_data;
      n.rsp_valid[c.grant_id] = 1'b1;
      n.busy = 0;
    end
    n.sleep_ack = n.sleeping;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("m_valid",     o_valid,     m.valid);
      check("m_rd0_wr1",   o_rd0_wr1,   m.rd0_wr1);
      check("m_addr",      o_addr,      m.addr);
      check("m_wr_data",   o_wr_data,   m.wr_data);
      check("m_req_ready", o_req_ready, m.req_ready);
      check("m_rsp_valid", o_rsp_valid, m.rsp_valid);
      check("m_rsp_data",  o_rsp_data,  m.rsp_data);
      check("m_sleep_ack", o_sleep_ack, m.sleep_ack);
      check("m_grant_id",  o_grant_id,  m.grant_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    tick(); tick();
    started = 1'b1;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_req_ready, 0);
    check("rst_ack",   o_sleep_ack, 0);
    check("rst_gid",   o_grant_id, 0);
    rst_n = 1'b1;
    tick();

    // Single write, master always ready.
    req_valid = 2'b01; req_rd0_wr1 = 2'b01;
    req_addr[31:0] = 32'h0000_1000; req_wr_data[31:0] = 32'hA5A5_A5A5;
    i_ready = 1'b1;
    tick();
    check("w_valid", o_valid, 1);
    check("w_addr",  o_addr, 32'h0000_1000);
    check("w_data",  o_wr_data, 32'hA5A5_A5A5);
    check("w_dir",   o_rd0_wr1, 1);
    check("w_ready", o_req_ready, 2'b01);
    req_valid = '0;
    tick();
    check("w_valid_drop", o_valid, 0);
    check("w_ready_drop", o_req_ready, 0);
    tick();

    // Read with three stalled cycles.
    i_ready = 1'b0;
    req_valid = 2'b10; req_rd0_wr1 = 2'b00; req_addr[63:32] = 32'h0000_0020;
    tick();
    check("r_ready", o_req_ready, 2'b10);
    check("r_gid",   o_grant_id, 1);
    check("r_addr",  o_addr, 32'h0000_0020);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      check("r_valid_held", o_valid, 1);
      tick();
    end
    check("r_valid_4th", o_valid, 1);
    i_ready = 1'b1;
    tick();
    check("r_valid_drop", o_valid, 0);
    i_ready = 1'b0;
    i_rd_valid = 1'b1; i_rd_data = 32'hDEAD_BEEF;
    tick();
    check("r_rsp_valid", o_rsp_valid, 2'b10);
    check("r_rsp_data",  o_rsp_data, 32'hDEAD_BEEF);
    i_rd_valid = 1'b0;
    tick();
    check("r_rsp_pulse", o_rsp_valid, 0);
    i_rd_valid = 1'b1; i_rd_data = 32'h0BAD_0BAD;
    tick();
    check("r_stray_rd", o_rsp_valid, 0);
    check("r_data_hold", o_rsp_data, 32'hDEAD_BEEF);
    i_rd_valid = 1'b0;

    // Fairness: both requesters write continuously.
    req_valid = 2'b11; req_rd0_wr1 = 2'b11;
    req_addr = {32'h0000_2004, 32'h0000_2000};
    req_wr_data = {32'h1111_1111, 32'h2222_2222};
    i_ready = 1'b1;
    grants = 0;
    for (int c = 0; c < 20 && grants < 6; c++) begin
      tick();
      if (o_req_ready != '0) begin
        check("fair_ready", o_req_ready, (grants % 2 == 0) ? 2'b01 : 2'b10);
        check("fair_gid",   o_grant_id, grants % 2);
        grants++;
      end
    end
    check("fair_count", grants, 6);
    req_valid = '0;
    tick(); tick();

    // Sleep raised while a read is being issued.
    i_ready = 1'b0;
    req_valid = 2'b01; req_rd0_wr1 = 2'b00; req_addr[31:0] = 32'h0000_0040;
    tick();
    check("s_ready", o_req_ready, 2'b01);
    req_valid = '0; i_sleep_req = 1'b1;
    tick();
    check("s_valid_held", o_valid, 1);
    check("s_ack_issue", o_sleep_ack, 0);
    i_ready = 1'b1;
    tick();
    check("s_valid_drop", o_valid, 0);
    i_ready = 1'b0; i_rd_valid = 1'b1; i_rd_data = 32'h1234_5678;
    tick();
    check("s_rsp_valid", o_rsp_valid, 2'b01);
    check("s_rsp_data", o_rsp_data, 32'h1234_5678);
    check("s_ack_rsp", o_sleep_ack, 0);
    i_rd_valid = 1'b0;
    req_valid = 2'b01; req_rd0_wr1 = 2'b01;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("s_ack_on", o_sleep_ack, 1);
      check("s_no_grant", o_req_ready, 0);
    end
    i_sleep_req = 1'b0;
    tick();
    check("s_ack_off", o_sleep_ack, 0);
    check("s_no_grant_wake", o_req_ready, 0);
    tick();
    check("s_wake_grant", o_req_ready, 2'b01);
    req_valid = '0; i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // Sleep and request arrive together in IDLE.
    req_valid = 2'b10; req_rd0_wr1 = 2'b10; i_sleep_req = 1'b1;
    tick();
    check("ss_ack", o_sleep_ack, 1);
    check("ss_no_grant", o_req_ready, 0);
    tick();
    check("ss_no_grant2", o_req_ready, 0);
    i_sleep_req = 1'b0;
    tick();
    check("ss_ack_off", o_sleep_ack, 0);
    tick();
    check("ss_grant", o_req_ready, 2'b10);
    req_valid = '0; i_ready = 1'b1;
    tick();

    // Reset while waiting for read data; pointer must return to requester 0.
    req_valid = 2'b01; req_rd0_wr1 = 2'b00; req_addr[31:0] = 32'h0000_0080;
    tick();
    check("rm_grant", o_req_ready, 2'b01);
    req_valid = '0;
    tick();
    i_ready = 1'b0; i_rd_valid = 1'b1; i_rd_data = 32'hCAFE_F00D;
    rst_n = 1'b0;
    #1;
    check("rm_valid", o_valid, 0);
    check("rm_rsp_valid", o_rsp_valid, 0);
    check("rm_rsp_data", o_rsp_data, 0);
    check("rm_addr", o_addr, 0);
    tick();
    rst_n = 1'b1; i_rd_valid = 1'b0;
    tick();
    check("rm_no_rsp", o_rsp_valid, 0);
    req_valid = 2'b11; req_rd0_wr1 = 2'b11; i_ready = 1'b1;
    tick();
    check("rm_first_grant", o_req_ready, 2'b01);
    check("rm_gid", o_grant_id, 0);
    req_valid = '0;
    tick(); tick();

    // Randomized traffic; requesters follow the hold-until-accepted rule.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m.req_ready[i] || !req_valid[i]) begin
          if (($urandom % 3) == 0) begin
            req_valid[i]              = 1'b1;
            req_rd0_wr1[i]            = 1'($urandom % 2);
            req_addr[i*AW +: AW]      = $urandom;
            req_wr_data[i*DW +: DW]   = $urandom;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      i_ready    = ($urandom % 3) != 0;
      i_rd_valid = 1'($urandom % 2);
      i_rd_data  = $urandom;
      if (($urandom % 40) == 0) i_sleep_req = ~i_sleep_req;
      tick();
    end

    req_valid = '0; i_sleep_req = 1'b0; i_ready = 1'b1; i_rd_valid = 1'b1;
    tick(); tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
